// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline stage registers of the CPU.
// State codes double as the stage occupancy count.
package pipe_pkg;

    localparam int XLEN      = 32;
    localparam int STAGE_NCH = 7;

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_FULL   = 2'd1,
        ST_SKFULL = 2'd2
    } stage_state_t;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready handshake bundle around one pipeline stage: upstream (in_*) and downstream (out_*).
// The stage itself uses the slave view; the driving environment uses the master view.
interface pipe_stage_reg_if
    import pipe_pkg::*;
#(
    parameter int W = XLEN * STAGE_NCH
);

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

endinterface

// File: rtl/pipe_data_reg.sv
// Wide payload register with asynchronous reset; clear wins over load.
module pipe_data_reg #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         clr,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] q_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_reg <= '0;
        end else if (clr) begin
            q_reg <= '0;
        end else if (load) begin
            q_reg <= d;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic valid/ready pipeline stage with flush and an optional skid entry.
// The main register is zeroed whenever it is vacated so a bubble reads as a NOP.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = XLEN,
    parameter int NCH    = STAGE_NCH,
    parameter bit SKID   = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    pipe_stage_reg_if.slave         bus,
    output logic [1:0]              occupancy
);

    localparam int W = NCH * DATA_W;

    stage_state_t state_reg;
    logic         in_fire;
    logic         out_fire;
    logic         m_load;
    logic         m_clr;
    logic [W-1:0] m_d;
    logic [W-1:0] m_q;
    logic [W-1:0] s_q;

    assign bus.out_valid = (state_reg != ST_EMPTY);
    // With a skid entry in_ready comes straight from the state flops; without it, it sees out_ready.
    assign bus.in_ready  = SKID ? (state_reg != ST_SKFULL)
                                : (!bus.out_valid || bus.out_ready);
    assign in_fire       = bus.in_valid  & bus.in_ready;
    assign out_fire      = bus.out_valid & bus.out_ready;
    assign occupancy     = state_reg;
    assign bus.out_data  = m_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_EMPTY;
        end else if (flush) begin
            state_reg <= ST_EMPTY;
        end else begin
            case (state_reg)
                ST_EMPTY: begin
                    if (in_fire) state_reg <= ST_FULL;
                end
                ST_FULL: begin
                    if (in_fire && !out_fire && SKID) state_reg <= ST_SKFULL;
                    else if (out_fire && !in_fire)    state_reg <= ST_EMPTY;
                end
                ST_SKFULL: begin
                    if (out_fire) state_reg <= ST_FULL;
                end
                default: state_reg <= ST_EMPTY;
            endcase
        end
    end

    // M reloads from S when draining the skid entry, otherwise from upstream.
    assign m_d    = (state_reg == ST_SKFULL) ? s_q : bus.in_data;
    assign m_load = (in_fire && (state_reg == ST_EMPTY || out_fire))
                 || (out_fire && state_reg == ST_SKFULL);
    assign m_clr  = flush || (out_fire && !in_fire && state_reg == ST_FULL);

    pipe_data_reg #(.W(W)) u_main (
        .clk  (clk),
        .rst  (rst),
        .load (m_load),
        .clr  (m_clr),
        .d    (m_d),
        .q    (m_q)
    );

    generate
        if (SKID) begin : g_skid
            logic s_load;
            logic s_clr;

            assign s_load = in_fire && !out_fire && (state_reg == ST_FULL);
            assign s_clr  = flush || (out_fire && state_reg == ST_SKFULL);

            pipe_data_reg #(.W(W)) u_skid (
                .clk  (clk),
                .rst  (rst),
                .load (s_load),
                .clr  (s_clr),
                .d    (bus.in_data),
                .q    (s_q)
            );
        end else begin : g_noskid
            assign s_q = '0;
        end
    endgenerate

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed and random checks of pipe_stage_reg (skid and non-skid builds) against a queue
// scoreboard: beats are pushed on predicted in-fire and popped on predicted out-fire.
module tb_pipe_stage_reg;
    import pipe_pkg::*;

    localparam int W1 = XLEN * STAGE_NCH;
    localparam int W0 = 24;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush1;
    logic       flush0;
    logic [1:0] occ1;
    logic [1:0] occ0;

    int n_assert = 0;
    int n_fail   = 0;
    int n_deliv1 = 0;

    logic [W1-1:0] q1[$];
    logic [W0-1:0] q0[$];

    always #5 clk = ~clk;

    pipe_stage_reg_if #(.W(W1)) bus1 ();
    pipe_stage_reg_if #(.W(W0)) bus0 ();

    pipe_stage_reg #(.DATA_W(XLEN), .NCH(STAGE_NCH), .SKID(1'b1)) u_dut1 (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush1),
        .bus       (bus1.slave),
        .occupancy (occ1)
    );

    pipe_stage_reg #(.DATA_W(8), .NCH(3), .SKID(1'b0)) u_dut0 (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush0),
        .bus       (bus0.slave),
        .occupancy (occ0)
    );

    task automatic chk(input string tag, input logic [W1-1:0] obs, input logic [W1-1:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock of the skid stage: drive, check against the model, then advance the model.
    task automatic cyc1(input logic iv, input logic [W1-1:0] d, input logic ordy,
                        input logic fl, input string tag);
        logic          exp_rdy;
        logic          exp_vld;
        logic          ifire;
        logic          ofire;
        logic [W1-1:0] exp_data;
        bus1.in_valid  = iv;
        bus1.in_data   = d;
        bus1.out_ready = ordy;
        flush1         = fl;
        #1;
        exp_vld  = (q1.size() > 0);
        exp_rdy  = (q1.size() < 2);
        exp_data = exp_vld ? q1[0] : '0;
        chk({tag, ".ctl1"}, {bus1.in_ready, bus1.out_valid, occ1},
            {exp_rdy, exp_vld, 2'(q1.size())});
        chk({tag, ".data1"}, bus1.out_data, exp_data);
        ifire = iv & exp_rdy;
        ofire = exp_vld & ordy;
        @(posedge clk);
        if (ofire) begin
            $display("dut1 %s delivered %0h", tag, exp_data);
            n_deliv1++;
            void'(q1.pop_front());
        end
        if (ifire) q1.push_back(d);
        if (fl) q1.delete();
        @(negedge clk);
    endtask

    // One clock of the single-entry stage.
    task automatic cyc0(input logic iv, input logic [W0-1:0] d, input logic ordy,
                        input logic fl, input string tag);
        logic          exp_rdy;
        logic          exp_vld;
        logic          ifire;
        logic          ofire;
        logic [W0-1:0] exp_data;
        bus0.in_valid  = iv;
        bus0.in_data   = d;
        bus0.out_ready = ordy;
        flush0         = fl;
        #1;
        exp_vld  = (q0.size() > 0);
        exp_rdy  = (q0.size() == 0) || ordy;
        exp_data = exp_vld ? q0[0] : '0;
        chk({tag, ".ctl0"}, {bus0.in_ready, bus0.out_valid, occ0},
            {exp_rdy, exp_vld, 2'(q0.size())});
        chk({tag, ".data0"}, bus0.out_data, exp_data);
        ifire = iv & exp_rdy;
        ofire = exp_vld & ordy;
        @(posedge clk);
        if (ofire) begin
            $display("dut0 %s delivered %0h", tag, exp_data);
            void'(q0.pop_front());
        end
        if (ifire) q0.push_back(d);
        if (fl) q0.delete();
        @(negedge clk);
    endtask

    initial begin
        logic [W1-1:0] rd1;
        int            deliv_before;
        rst            = 1'b1;
        flush1         = 1'b0;
        flush0         = 1'b0;
        bus1.in_valid  = 1'b0;
        bus1.in_data   = '0;
        bus1.out_ready = 1'b0;
        bus0.in_valid  = 1'b0;
        bus0.in_data   = '0;
        bus0.out_ready = 1'b0;
        @(negedge clk);

        // Reset state
        cyc1(1'b0, '0, 1'b1, 1'b0, "reset_a");
        cyc1(1'b0, '0, 1'b1, 1'b0, "reset_b");
        chk("reset0", {bus0.in_ready, bus0.out_valid, occ0, bus0.out_data}, {1'b1, 1'b0, 2'd0, 24'h0});
        rst = 1'b0;

        // Streaming at full rate
        cyc1(1'b1, W1'(32'h11), 1'b1, 1'b0, "s1");
        cyc1(1'b1, W1'(32'h22), 1'b1, 1'b0, "s2");
        cyc1(1'b1, W1'(32'h33), 1'b1, 1'b0, "s3");
        cyc1(1'b0, '0, 1'b1, 1'b0, "s4");
        cyc1(1'b0, '0, 1'b1, 1'b0, "s5");

        // Stall absorbed by the skid entry
        cyc1(1'b1, W1'(32'hA), 1'b1, 1'b0, "k1");
        cyc1(1'b1, W1'(32'hB), 1'b0, 1'b0, "k2");
        cyc1(1'b0, '0, 1'b0, 1'b0, "k3");
        cyc1(1'b0, '0, 1'b1, 1'b0, "k4");
        cyc1(1'b0, '0, 1'b1, 1'b0, "k5");
        cyc1(1'b0, '0, 1'b1, 1'b0, "k6");

        // Flush while SKFULL with a pending beat, then flush discarding a concurrent in-fire
        cyc1(1'b1, W1'(32'hA), 1'b0, 1'b0, "f1");
        cyc1(1'b1, W1'(32'hB), 1'b0, 1'b0, "f2");
        cyc1(1'b1, W1'(32'hC), 1'b0, 1'b1, "f3");
        cyc1(1'b0, '0, 1'b0, 1'b0, "f4");
        cyc1(1'b1, W1'(32'hD), 1'b0, 1'b0, "f5");
        cyc1(1'b1, W1'(32'hE), 1'b0, 1'b1, "f6");
        cyc1(1'b0, '0, 1'b1, 1'b0, "f7");

        // Flush with a concurrent out-fire: delivered exactly once
        cyc1(1'b1, W1'(32'h5), 1'b0, 1'b0, "o1");
        deliv_before = n_deliv1;
        cyc1(1'b0, '0, 1'b1, 1'b1, "o2");
        cyc1(1'b0, '0, 1'b1, 1'b0, "o3");
        chk("flush_deliver_once", W1'(n_deliv1 - deliv_before), W1'(1));

        // Asynchronous reset in the middle of operation
        cyc1(1'b1, W1'(32'h7), 1'b0, 1'b0, "r1");
        cyc1(1'b1, W1'(32'h8), 1'b0, 1'b0, "r2");
        bus1.in_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("async_rst", {bus1.in_ready, bus1.out_valid, occ1, bus1.out_data},
            {1'b1, 1'b0, 2'd0, {W1{1'b0}}});
        q1.delete();
        @(negedge clk);
        rst = 1'b0;
        cyc1(1'b0, '0, 1'b1, 1'b0, "r3");

        // Single-entry build: same-cycle backpressure and full-rate push/pop
        cyc0(1'b1, 24'h010203, 1'b0, 1'b0, "z1");
        cyc0(1'b1, 24'h040506, 1'b0, 1'b0, "z2");
        cyc0(1'b1, 24'h040506, 1'b1, 1'b0, "z3");
        cyc0(1'b0, '0, 1'b0, 1'b0, "z4");
        chk("ch1_second_beat", W1'(bus0.out_data[15:8]), W1'(8'h05));
        cyc0(1'b1, 24'h0A0B0C, 1'b1, 1'b1, "z5");
        cyc0(1'b0, '0, 1'b1, 1'b0, "z6");

        // Random traffic with occasional flush
        for (int i = 0; i < 10000; i++) begin
            for (int k = 0; k < STAGE_NCH; k++) rd1[k*XLEN +: XLEN] = $urandom();
            cyc1(1'($urandom_range(0, 1)), rd1, 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 99) < 2), "rnd1");
        end
        for (int i = 0; i < 2000; i++) begin
            cyc0(1'($urandom_range(0, 1)), 24'($urandom()), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 99) < 2), "rnd0");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
